// File: rtl/dlx_pkg.sv
`default_nettype none
// ============================================================================
// Module : dlx_pkg
// Brief  : Shared types, opcode constants and field slicers for the DLX issue block
// Rev    : 1.0
// ============================================================================
package dlx_pkg;

    typedef enum logic [4:0] {
        ALU_LHI  = 5'd0,
        ALU_ADD  = 5'd1,
        ALU_SUB  = 5'd2,
        ALU_AND  = 5'd3,
        ALU_OR   = 5'd4,
        ALU_XOR  = 5'd5,
        ALU_SLL  = 5'd6,
        ALU_SRL  = 5'd7,
        ALU_ADDU = 5'd8,
        ALU_SUBU = 5'd9,
        ALU_SEQ  = 5'd10,
        ALU_SLE  = 5'd11,
        ALU_SLT  = 5'd12,
        ALU_SNE  = 5'd13,
        ALU_SRA  = 5'd14,
        ALU_SGE  = 5'd15,
        ALU_SGT  = 5'd16,
        ALU_NOP  = 5'd17
    } alu_op_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2,
        S_WB     = 2'd3
    } state_e;

    localparam logic [5:0] c_OPC_RTYPE = 6'h00;
    localparam logic [5:0] c_OPC_ADDI  = 6'h08;
    localparam logic [5:0] c_OPC_SUBI  = 6'h0A;
    localparam logic [5:0] c_OPC_ANDI  = 6'h0C;
    localparam logic [5:0] c_OPC_ORI   = 6'h0D;
    localparam logic [5:0] c_OPC_XORI  = 6'h0E;
    localparam logic [5:0] c_OPC_LHI   = 6'h0F;
    localparam logic [5:0] c_OPC_SLLI  = 6'h14;
    localparam logic [5:0] c_OPC_SRLI  = 6'h16;
    localparam logic [5:0] c_OPC_SRAI  = 6'h17;
    localparam logic [5:0] c_OPC_SEQI  = 6'h18;
    localparam logic [5:0] c_OPC_SNEI  = 6'h19;
    localparam logic [5:0] c_OPC_SLTI  = 6'h1A;
    localparam logic [5:0] c_OPC_SLEI  = 6'h1C;

    localparam logic [5:0] c_FUNC_SLL  = 6'h04;
    localparam logic [5:0] c_FUNC_SRL  = 6'h06;
    localparam logic [5:0] c_FUNC_SRA  = 6'h07;
    localparam logic [5:0] c_FUNC_ADD  = 6'h20;
    localparam logic [5:0] c_FUNC_SUB  = 6'h22;
    localparam logic [5:0] c_FUNC_AND  = 6'h24;
    localparam logic [5:0] c_FUNC_OR   = 6'h25;
    localparam logic [5:0] c_FUNC_XOR  = 6'h26;
    localparam logic [5:0] c_FUNC_SEQ  = 6'h28;
    localparam logic [5:0] c_FUNC_SNE  = 6'h29;
    localparam logic [5:0] c_FUNC_SLT  = 6'h2A;
    localparam logic [5:0] c_FUNC_SLE  = 6'h2C;

    localparam int c_OPC_LSB  = 26;
    localparam int c_RS1_LSB  = 21;
    localparam int c_RS2_LSB  = 16;
    localparam int c_RDR_LSB  = 11;
    localparam int c_RDI_LSB  = 16;
    localparam int c_FUNC_LSB = 0;
    localparam int c_IMM_LSB  = 0;

    function automatic logic [5:0] f_opcode(input logic [31:0] ins);
        return ins[c_OPC_LSB +: 6];
    endfunction

    function automatic logic [5:0] f_func(input logic [31:0] ins);
        return ins[c_FUNC_LSB +: 6];
    endfunction

    function automatic logic [4:0] f_rs1(input logic [31:0] ins);
        return ins[c_RS1_LSB +: 5];
    endfunction

    function automatic logic [4:0] f_rs2(input logic [31:0] ins);
        return ins[c_RS2_LSB +: 5];
    endfunction

    function automatic logic [4:0] f_rd_r(input logic [31:0] ins);
        return ins[c_RDR_LSB +: 5];
    endfunction

    function automatic logic [4:0] f_rd_i(input logic [31:0] ins);
        return ins[c_RDI_LSB +: 5];
    endfunction

    function automatic logic [15:0] f_imm(input logic [31:0] ins);
        return ins[c_IMM_LSB +: 16];
    endfunction

endpackage
`default_nettype wire

// File: rtl/dlx_alu_issue_if.sv
`default_nettype none
// ============================================================================
// Module : dlx_alu_issue_if
// Brief  : Instruction handshake, ALU producer side and writeback bundle
// Rev    : 1.0
// ============================================================================
interface dlx_alu_issue_if #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       instr;
    logic              EX;
    logic [4:0]        I;
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
    logic [DATA_W-1:0] res1;
    logic              carry;
    logic              z;
    logic              wb_valid;
    logic [4:0]        wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic              wb_carry;
    logic              wb_z;
    logic              illegal;

    modport slave (
        input  in_valid, instr, res1, carry, z,
        output in_ready, EX, I, op1, op2,
               wb_valid, wb_rd, wb_data, wb_carry, wb_z, illegal
    );

    modport master (
        output in_valid, instr, res1, carry, z,
        input  in_ready, EX, I, op1, op2,
               wb_valid, wb_rd, wb_data, wb_carry, wb_z, illegal
    );
endinterface
`default_nettype wire

// File: rtl/dlx_regfile.sv
`default_nettype none
// ============================================================================
// Module : dlx_regfile
// Brief  : NREG x DATA_W register file, two async reads, one sync write, r0 = 0
// Rev    : 1.0
// ============================================================================
module dlx_regfile #(
    parameter int DATA_W = 32,
    parameter int NREG   = 32,
    parameter int AW     = $clog2(NREG)
) (
    input  wire               clk,
    input  wire               rst,
    input  wire  [AW-1:0]     i_raddr1,
    input  wire  [AW-1:0]     i_raddr2,
    output logic [DATA_W-1:0] o_rdata1,
    output logic [DATA_W-1:0] o_rdata2,
    input  wire               i_we,
    input  wire  [AW-1:0]     i_waddr,
    input  wire  [DATA_W-1:0] i_wdata
);
    logic [DATA_W-1:0] r_mem [NREG];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we && (i_waddr != '0)) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata1 = (i_raddr1 == '0) ? '0 : r_mem[i_raddr1];
    assign o_rdata2 = (i_raddr2 == '0) ? '0 : r_mem[i_raddr2];
endmodule
`default_nettype wire

// File: rtl/dlx_alu_issue.sv
`default_nettype none
// ============================================================================
// Module : dlx_alu_issue
// Brief  : 4-cycle DLX issue/writeback sequencer feeding the registered DLX ALU
// Rev    : 1.0
// ============================================================================
module dlx_alu_issue
    import dlx_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NREG   = 32
) (
    input  wire            clk,
    input  wire            reset,
    dlx_alu_issue_if.slave bus
);
    state_e            r_state;
    logic [31:0]       r_instr;
    logic              r_in_ready;
    logic              r_ex;
    alu_op_e           r_alu_op;
    logic [DATA_W-1:0] r_op1;
    logic [DATA_W-1:0] r_op2;
    logic              r_wb_valid;
    logic [4:0]        r_wb_rd;
    logic              r_illegal;

    logic [DATA_W-1:0] w_rdata1;
    logic [DATA_W-1:0] w_rdata2;
    logic              w_legal;
    alu_op_e           w_alu_op;
    logic [DATA_W-1:0] w_op1;
    logic [DATA_W-1:0] w_op2;
    logic [4:0]        w_rd;
    logic [15:0]       w_imm;
    logic [DATA_W-1:0] w_imm_s;
    logic [DATA_W-1:0] w_imm_z;

    dlx_regfile #(
        .DATA_W (DATA_W),
        .NREG   (NREG),
        .AW     (5)
    ) u_regfile (
        .clk      (clk),
        .rst      (reset),
        .i_raddr1 (f_rs1(r_instr)),
        .i_raddr2 (f_rs2(r_instr)),
        .o_rdata1 (w_rdata1),
        .o_rdata2 (w_rdata2),
        .i_we     (r_state == S_WB),
        .i_waddr  (r_wb_rd),
        .i_wdata  (bus.res1)
    );

    assign w_imm   = f_imm(r_instr);
    assign w_imm_s = {{(DATA_W-16){w_imm[15]}}, w_imm};
    assign w_imm_z = {{(DATA_W-16){1'b0}}, w_imm};

    always_comb begin
        w_legal  = 1'b1;
        w_alu_op = ALU_ADD;
        w_op1    = w_rdata1;
        w_op2    = w_rdata2;
        w_rd     = f_rd_r(r_instr);
        if (f_opcode(r_instr) == c_OPC_RTYPE) begin
            case (f_func(r_instr))
                c_FUNC_ADD: w_alu_op = ALU_ADD;
                c_FUNC_SUB: w_alu_op = ALU_SUB;
                c_FUNC_AND: w_alu_op = ALU_AND;
                c_FUNC_OR:  w_alu_op = ALU_OR;
                c_FUNC_XOR: w_alu_op = ALU_XOR;
                c_FUNC_SLL: w_alu_op = ALU_SLL;
                c_FUNC_SRL: w_alu_op = ALU_SRL;
                c_FUNC_SRA: w_alu_op = ALU_SRA;
                c_FUNC_SEQ: w_alu_op = ALU_SEQ;
                c_FUNC_SNE: w_alu_op = ALU_SNE;
                c_FUNC_SLT: w_alu_op = ALU_SLT;
                c_FUNC_SLE: w_alu_op = ALU_SLE;
                default:    w_legal  = 1'b0;
            endcase
        end else begin
            // Logical immediates are zero-extended; LHI shifts imm into the
            // upper half inside the ALU, so op1 carries nothing.
            w_rd  = f_rd_i(r_instr);
            w_op2 = w_imm_s;
            case (f_opcode(r_instr))
                c_OPC_ADDI: w_alu_op = ALU_ADD;
                c_OPC_SUBI: w_alu_op = ALU_SUB;
                c_OPC_ANDI: begin w_alu_op = ALU_AND; w_op2 = w_imm_z; end
                c_OPC_ORI:  begin w_alu_op = ALU_OR;  w_op2 = w_imm_z; end
                c_OPC_XORI: begin w_alu_op = ALU_XOR; w_op2 = w_imm_z; end
                c_OPC_LHI:  begin w_alu_op = ALU_LHI; w_op2 = w_imm_z; w_op1 = '0; end
                c_OPC_SLLI: w_alu_op = ALU_SLL;
                c_OPC_SRLI: w_alu_op = ALU_SRL;
                c_OPC_SRAI: w_alu_op = ALU_SRA;
                c_OPC_SEQI: w_alu_op = ALU_SEQ;
                c_OPC_SNEI: w_alu_op = ALU_SNE;
                c_OPC_SLTI: w_alu_op = ALU_SLT;
                c_OPC_SLEI: w_alu_op = ALU_SLE;
                default:    w_legal  = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_instr    <= '0;
            r_in_ready <= 1'b1;
            r_ex       <= 1'b0;
            r_alu_op   <= ALU_LHI;
            r_op1      <= '0;
            r_op2      <= '0;
            r_wb_valid <= 1'b0;
            r_wb_rd    <= '0;
            r_illegal  <= 1'b0;
        end else begin
            r_illegal <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid && r_in_ready) begin
                        r_instr    <= bus.instr;
                        r_in_ready <= 1'b0;
                        r_state    <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (!w_legal) begin
                        r_illegal  <= 1'b1;
                        r_in_ready <= 1'b1;
                        r_state    <= S_IDLE;
                    end else begin
                        r_alu_op <= w_alu_op;
                        r_op1    <= w_op1;
                        r_op2    <= w_op2;
                        r_wb_rd  <= w_rd;
                        r_ex     <= 1'b1;
                        r_state  <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_ex       <= 1'b0;
                    r_wb_valid <= 1'b1;
                    r_state    <= S_WB;
                end
                default: begin
                    r_wb_valid <= 1'b0;
                    r_in_ready <= 1'b1;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

    // The ALU result is itself registered, so writeback forwards it live in WB.
    assign bus.in_ready = r_in_ready;
    assign bus.EX       = r_ex;
    assign bus.I        = r_alu_op;
    assign bus.op1      = r_op1;
    assign bus.op2      = r_op2;
    assign bus.wb_valid = r_wb_valid;
    assign bus.wb_rd    = r_wb_rd;
    assign bus.wb_data  = r_wb_valid ? bus.res1 : '0;
    assign bus.wb_carry = r_wb_valid & bus.carry;
    assign bus.wb_z     = r_wb_valid & bus.z;
    assign bus.illegal  = r_illegal;
endmodule
`default_nettype wire
